regfile_cb: RTL
===============

Name: regfile_cb

Overview:
- Architectural state block directly upstream and downstream of the 8-bit ALU: 8 general registers ($r0-$r7) plus the 1-bit condition bit (CB).
- Supplies the ALU rs/rt operands through two combinational read ports.
- Captures the ALU result, or the set-immediate value, on a synchronous write port.
- Latches the ALU zero/compare flag (slt, seq) into CB for downstream branch logic.

Parameters:
- DATA_WIDTH, 8, register and port data width.
- ADDR_WIDTH, 3, register address width; the register count is 2**ADDR_WIDTH (8).
- RESET_VALUE, 8'h00, value loaded into every register on reset.

Ports:
- clk_i  input  1  single clock; all state updates on the rising edge.
- reset_i  input  1  synchronous, active-high reset.
- rs_addr_i  input  ADDR_WIDTH  read port A address (ALU rs operand).
- rt_addr_i  input  ADDR_WIDTH  read port B address (ALU rt operand; the decoder drives 3'd7 for implicit-$r7 ops).
- rs_o  output  DATA_WIDTH  read port A data.
- rt_o  output  DATA_WIDTH  read port B data.
- reg_write_i  input  1  register write enable.
- rd_addr_i  input  ADDR_WIDTH  write destination.
- rd_data_i  input  DATA_WIDTH  write data (ALU result or set immediate).
- cb_write_i  input  1  CB write enable, asserted for slt/seq.
- cb_data_i  input  1  new CB value (ALU zero output).
- cb_o  output  1  current CB.
- dbg_addr_i  input  ADDR_WIDTH  debug read address.
- dbg_data_o  output  DATA_WIDTH  debug read data (combinational, never bypassed).

Behaviour:
- One clock (clk_i); reset_i is synchronous and active-high.
- Reset:
  - While reset_i is high at a rising edge, all 8 registers load RESET_VALUE and CB loads 0.
  - Reset has priority over reg_write_i and cb_write_i in the same cycle; a write issued in a reset cycle is discarded.
  - Reset asserted mid-program clears all state at the next edge; no write from that cycle survives.
- Reads:
  - rs_o, rt_o and dbg_data_o are combinational from the register array; no read latency.
  - rs_addr_i equal to rt_addr_i is legal; both ports return the same value.
- Register write:
  - When reg_write_i=1 at a rising edge (no reset), reg[rd_addr_i] <= rd_data_i.
  - The new value is visible on the read ports the cycle after the edge.
  - All 8 registers are writable; $r0 is not hardwired.
- CB write:
  - When cb_write_i=1 at a rising edge (no reset), CB <= cb_data_i; otherwise CB holds.
  - reg_write_i and cb_write_i may both be asserted in one cycle; both updates occur independently at the same edge.
- Same-cycle read of the address being written (no bypass): the read port returns the old stored value during that cycle and the new value from the next cycle.
- Out-of-range addresses cannot occur: the address width covers exactly the register count.
- Outputs after reset: rs_o = rt_o = dbg_data_o = RESET_VALUE, cb_o = 0.
- Internal storage: flip-flop array DATA_WIDTH x 8 plus a 1-bit CB flop. No latches. Every output is driven on every path.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-to-read forwarding.
  - If reg_write_i=1 and rd_addr_i==rs_addr_i, rs_o = rd_data_i in the same cycle; likewise for rt_o.
  - If cb_write_i=1, cb_o = cb_data_i in the same cycle.
  - Forwarding is suppressed while reset_i=1.
  - dbg_data_o is never bypassed.
- Not defined: purely registered read-after-write as described under Behaviour.

Test Plan:
- Reset then read: assert reset_i 1 cycle; read all 8 addresses on rs and rt -> every read 8'h00, cb_o=0.
- Write/readback: write 8'hA5 to $r3 and 8'h3C to $r7; set rs_addr=3, rt_addr=7 -> next cycle rs_o=8'hA5, rt_o=8'h3C; all other registers still 8'h00.
- CB update and hold:
  - cb_write_i=1, cb_data_i=1 -> cb_o=1 next cycle.
  - Two cycles with cb_write_i=0 and cb_data_i=0 -> cb_o stays 1.
  - cb_write_i=1, cb_data_i=0 -> cb_o=0.
- Reset priority: $r5=8'h11; in one cycle assert reset_i with reg_write_i=1, rd_addr=5, rd_data=8'hFF and cb_write_i=1, cb_data_i=1 -> next cycle $r5=8'h00, cb_o=0.
- Same-cycle RAW: $r2=8'h10; write 8'h20 to $r2 while rs_addr=2 -> that cycle rs_o=8'h10 without REGFILE_BYPASS_EN, 8'h20 with it; next cycle rs_o=8'h20 in both builds; dbg_data_o (dbg_addr=2) = 8'h10 that cycle in both builds.
- Dual write: in one cycle write 8'h7E to $r0 with cb_write_i=1, cb_data_i=1 -> next cycle $r0=8'h7E and cb_o=1, with no other register changed.

Source files
------------

// File: rtl/regfile_cb.sv
// regfile_cb: 8 general registers plus condition bit, two combinational read ports and a debug port.
// Optional REGFILE_BYPASS_EN macro forwards same-cycle writes to rs_o/rt_o/cb_o.
module regfile_cb #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [ADDR_WIDTH-1:0] rs_addr_i,
  input  logic [ADDR_WIDTH-1:0] rt_addr_i,
  output logic [DATA_WIDTH-1:0] rs_o,
  output logic [DATA_WIDTH-1:0] rt_o,
  input  logic                  reg_write_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  input  logic [DATA_WIDTH-1:0] rd_data_i,
  input  logic                  cb_write_i,
  input  logic                  cb_data_i,
  output logic                  cb_o,
  input  logic [ADDR_WIDTH-1:0] dbg_addr_i,
  output logic [DATA_WIDTH-1:0] dbg_data_o
);
  localparam int NREG = 2**ADDR_WIDTH;
  logic [DATA_WIDTH-1:0] regs_q [NREG];
  logic [DATA_WIDTH-1:0] regs_d [NREG];
  logic                  cb_q, cb_d;
  always_comb begin
    for (int i = 0; i < NREG; i++)
      regs_d[i] = (reg_write_i && rd_addr_i == ADDR_WIDTH'(i)) ? rd_data_i : regs_q[i];
    cb_d = cb_write_i ? cb_data_i : cb_q;
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= RESET_VALUE;
      cb_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      cb_q   <= cb_d;
    end
  end
  assign dbg_data_o = regs_q[dbg_addr_i];
`ifdef REGFILE_BYPASS_EN
  always_comb begin
    rs_o = (!reset_i && reg_write_i && rd_addr_i == rs_addr_i) ? rd_data_i : regs_q[rs_addr_i];
    rt_o = (!reset_i && reg_write_i && rd_addr_i == rt_addr_i) ? rd_data_i : regs_q[rt_addr_i];
    cb_o = (!reset_i && cb_write_i) ? cb_data_i : cb_q;
  end
`else
  always_comb begin
    rs_o = regs_q[rs_addr_i];
    rt_o = regs_q[rt_addr_i];
    cb_o = cb_q;
  end
`endif
endmodule
